// File: rtl/control_pkg.sv
// Shared types and defaults for the recovery controller.
package control_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 5;

   typedef enum logic [1:0] {
      IDLE,
      REPLAY,
      DONE
   } ctrl_state_t;

endpackage

// File: rtl/control.sv
// Recovery controller: on an error, sweeps register addresses 0..NUM_REG-1
// one per cycle, then pulses done for one cycle and returns to idle.
module control
   import control_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int NUM_REG    = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  error_i,
   output logic [ADDR_WIDTH-1:0] replay_addr_o,
   output logic                  replay_valid_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REG - 1);

   ctrl_state_t           state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic                  valid_reg, valid_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;

   // Outputs for the next cycle are decoded alongside the next state so that
   // every output leaves the block straight from a flop.
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      valid_next = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            addr_next = '0;
            if (error_i) begin
               state_next = REPLAY;
               valid_next = 1'b1;
               busy_next  = 1'b1;
            end
         end
         REPLAY: begin
            if (error_i) begin
               addr_next  = '0;
               valid_next = 1'b1;
               busy_next  = 1'b1;
            end else if (addr_reg == LAST_ADDR) begin
               // Termination is by compare; the address holds during DONE.
               state_next = DONE;
               busy_next  = 1'b1;
               done_next  = 1'b1;
            end else begin
               addr_next  = addr_reg + 1'b1;
               valid_next = 1'b1;
               busy_next  = 1'b1;
            end
         end
         DONE: begin
            addr_next = '0;
            if (error_i) begin
               state_next = REPLAY;
               valid_next = 1'b1;
               busy_next  = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            addr_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         valid_reg <= valid_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign replay_addr_o  = addr_reg;
   assign replay_valid_o = valid_reg;
   assign busy_o         = busy_reg;
   assign done_o         = done_reg;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: vector table, directed corner sequences and
// randomized error/reset traffic against a cycles-since-last-error model.
module tb_control;
   import control_pkg::*;

   localparam int AW    = 5;
   localparam int NR    = 2**AW;
   localparam int NEVER = 1000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          error_i = 1'b0;
   logic [AW-1:0] replay_addr_o;
   logic          replay_valid_o;
   logic          busy_o;
   logic          done_o;

   int checks = 0;
   int errors = 0;
   // Edges since the last edge that sampled error_i high (NEVER = none since reset).
   int since = NEVER;

   control #(.ADDR_WIDTH(AW), .NUM_REG(NR)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .error_i        (error_i),
      .replay_addr_o  (replay_addr_o),
      .replay_valid_o (replay_valid_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          err;
      logic [AW-1:0] addr;
      logic          valid;
      logic          busy;
      logic          done;
   } vec_t;

   task automatic check_out(input string name, input logic [AW-1:0] ea, input logic ev,
                            input logic eb, input logic ed);
      checks++;
      if ({replay_addr_o, replay_valid_o, busy_o, done_o} !== {ea, ev, eb, ed}) begin
         errors++;
         $display("FAIL %s @%0t: got addr=%0d valid=%b busy=%b done=%b, want addr=%0d valid=%b busy=%b done=%b",
                  name, $time, replay_addr_o, replay_valid_o, busy_o, done_o, ea, ev, eb, ed);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Expected outputs follow directly from how long ago the last error was seen.
   task automatic check_model(input string name);
      if (since < NR)       check_out(name, AW'(since), 1'b1, 1'b1, 1'b0);
      else if (since == NR) check_out(name, AW'(NR - 1), 1'b0, 1'b1, 1'b1);
      else                  check_out(name, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step(input logic e);
      @(negedge clk);
      error_i = e;
      @(posedge clk);
      if (rst_n) begin
         if (e) since = 0;
         else if (since < NEVER) since++;
      end
      #1;
   endtask

   task automatic mstep(input logic e, input string name, inout int dones, inout int done_at, input int idx);
      step(e);
      check_model(name);
      if (done_o === 1'b1) begin
         dones++;
         done_at = idx;
      end
   endtask

   // Assert reset mid-cycle, check immediately and for two held cycles.
   task automatic async_reset(input string name);
      #2;
      rst_n = 1'b0;
      since = NEVER;
      #1;
      check_out({name, "_immediate"}, '0, 1'b0, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_out({name, "_held"}, '0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t tbl[9];

   initial begin
      int dones, done_at;
      tbl[0] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 5'd0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 5'd1, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 5'd2, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 5'd3, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 5'd0, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 5'd0, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 5'd1, 1'b1, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 5'd2, 1'b1, 1'b1, 1'b0};

      // Power-on reset, then release with error low.
      #3;
      check_out("reset_start", '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_out("reset_hold", '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].err);
         check_out($sformatf("vec%0d", i), tbl[i].addr, tbl[i].valid, tbl[i].busy, tbl[i].done);
         $display("vec%0d err=%b addr=%0d valid=%b busy=%b done=%b", i, tbl[i].err,
                  replay_addr_o, replay_valid_o, busy_o, done_o);
      end

      // Finish the sweep the table started: exactly one done.
      dones = 0; done_at = -1;
      for (int i = 1; i <= 33; i++) mstep(1'b0, "table_tail", dones, done_at, i);
      check_int("table_tail_dones", dones, 1);
      $display("seq table_tail dones=%0d", dones);

      // Single pulse: done on the 32nd edge after the sampling edge.
      dones = 0; done_at = -1;
      mstep(1'b1, "pulse", dones, done_at, 0);
      for (int i = 1; i <= 35; i++) mstep(1'b0, "pulse", dones, done_at, i);
      check_int("pulse_dones", dones, 1);
      check_int("pulse_done_at", done_at, NR);
      $display("seq single_pulse done_at=%0d", done_at);

      // Long idle: nothing ever moves.
      dones = 0; done_at = -1;
      for (int i = 0; i < 60; i++) mstep(1'b0, "idle", dones, done_at, i);
      check_int("idle_dones", dones, 0);
      $display("seq no_error dones=%0d", dones);

      // Error at addr 10 restarts a complete sweep.
      dones = 0; done_at = -1;
      mstep(1'b1, "mid", dones, done_at, 0);
      for (int i = 1; i <= 10; i++) mstep(1'b0, "mid", dones, done_at, i);
      check_out("mid_at10", 5'd10, 1'b1, 1'b1, 1'b0);
      mstep(1'b1, "mid_restart", dones, done_at, 0);
      check_out("mid_restart_addr0", 5'd0, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 34; i++) mstep(1'b0, "mid", dones, done_at, i);
      check_int("mid_dones", dones, 1);
      check_int("mid_done_at", done_at, NR);
      $display("seq mid_restart dones=%0d done_at=%0d", dones, done_at);

      // Error held for 3 edges: addr pinned at 0 until it drops.
      dones = 0; done_at = -1;
      for (int i = 0; i < 3; i++) begin
         mstep(1'b1, "held", dones, done_at, 0);
         check_out("held_addr0", 5'd0, 1'b1, 1'b1, 1'b0);
      end
      for (int i = 1; i <= 34; i++) mstep(1'b0, "held", dones, done_at, i);
      check_int("held_dones", dones, 1);
      check_int("held_done_at", done_at, NR);
      $display("seq held3 done_at=%0d", done_at);

      // Reset at addr 20 aborts without done; then a normal sweep.
      dones = 0; done_at = -1;
      mstep(1'b1, "rst_mid", dones, done_at, 0);
      for (int i = 1; i <= 20; i++) mstep(1'b0, "rst_mid", dones, done_at, i);
      check_out("rst_mid_at20", 5'd20, 1'b1, 1'b1, 1'b0);
      async_reset("rst_mid");
      for (int i = 0; i < 40; i++) mstep(1'b0, "rst_after", dones, done_at, i);
      check_int("rst_mid_dones", dones, 0);
      mstep(1'b1, "rst_resweep", dones, done_at, 0);
      for (int i = 1; i <= 34; i++) mstep(1'b0, "rst_resweep", dones, done_at, i);
      check_int("rst_resweep_dones", dones, 1);
      check_int("rst_resweep_done_at", done_at, NR);
      $display("seq reset_mid_replay dones=%0d", dones);

      // Random error pulses and occasional asynchronous resets.
      dones = 0; done_at = -1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) async_reset("rand_reset");
         mstep(($urandom_range(0, 44) == 0) ? 1'b1 : 1'b0, "random", dones, done_at, i);
      end
      $display("seq random cycles=3000 dones=%0d", dones);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
